// File: rtl/approx_adder_error_monitor.sv
// Approximate-adder error monitor: error count, sum and max of |approx - exact|.
// Define ERR_MON_SIGNED_ERR_EN to build the saturating signed-error accumulator.
module approx_adder_error_monitor #(
    parameter int WIDTH       = 16,
    parameter int NUM_SAMPLES = 256,
    parameter int CNT_W       = 16,
    parameter int ACC_W       = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   add1_i,
    input  logic [WIDTH-1:0]   add2_i,
    input  logic [WIDTH:0]     approx_result_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   err_count_o,
    output logic [ACC_W-1:0]   sum_abs_err_o,
    output logic [WIDTH:0]     max_abs_err_o,
    output logic [ACC_W:0]     sum_sgn_err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int AW = WIDTH + 1;
    localparam int DW = WIDTH + 2;
    localparam int UW = ((ACC_W > AW) ? ACC_W : AW) + 1;
    localparam logic [UW-1:0] ACC_MAX = UW'((64'd1 << ACC_W) - 64'd1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               s1_v_q, s1_v_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [AW-1:0]      s1_r_q, s1_r_d;

    logic               s2_v_q, s2_v_d;
    logic               s2_nz_q, s2_nz_d;
    logic [AW-1:0]      s2_abs_q, s2_abs_d;

    logic [CNT_W-1:0]   err_q, err_d;
    logic [ACC_W-1:0]   abs_sum_q, abs_sum_d;
    logic [AW-1:0]      max_q, max_d;

    logic               fire;
    logic               clr;
    logic [AW-1:0]      exact;
    logic signed [DW-1:0] dif;
    logic [UW-1:0]      sum_ext;

`ifdef ERR_MON_SIGNED_ERR_EN
    localparam int SW = ((ACC_W + 1 > DW) ? ACC_W + 1 : DW) + 1;
    localparam logic signed [SW-1:0] SGN_MAX = SW'((64'd1 << ACC_W) - 64'd1);
    localparam logic signed [SW-1:0] SGN_MIN = ~SGN_MAX;

    logic signed [DW-1:0]  s2_dif_q, s2_dif_d;
    logic signed [ACC_W:0] sgn_q, sgn_d;
    logic signed [SW-1:0]  sgn_ext;
`endif

    assign fire = valid_i && (state_q == RUN);
    assign clr  = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (fire && (cnt_q == LAST)) state_d = DRAIN;
            // S2 empties on the same edge, so DONE lands with final metrics
            DRAIN:   if (!s1_v_q) state_d = DONE;
            DONE:    if (start_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);

        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        s1_v_d = fire;
        s1_a_d = s1_a_q;
        s1_b_d = s1_b_q;
        s1_r_d = s1_r_q;
        if (fire) begin
            s1_a_d = add1_i;
            s1_b_d = add2_i;
            s1_r_d = approx_result_i;
        end

        exact = AW'(s1_a_q) + AW'(s1_b_q);
        dif   = $signed({1'b0, s1_r_q}) - $signed({1'b0, exact});

        s2_v_d   = s1_v_q;
        s2_nz_d  = s2_nz_q;
        s2_abs_d = s2_abs_q;
        if (s1_v_q) begin
            s2_nz_d  = (dif != '0);
            s2_abs_d = dif[DW-1] ? AW'(-dif) : AW'(dif);
        end
`ifdef ERR_MON_SIGNED_ERR_EN
        s2_dif_d = s1_v_q ? dif : s2_dif_q;
`endif
    end

    always_comb begin
        err_d     = err_q;
        abs_sum_d = abs_sum_q;
        max_d     = max_q;
        sum_ext   = UW'(abs_sum_q) + UW'(s2_abs_q);
        if (clr) begin
            err_d     = '0;
            abs_sum_d = '0;
            max_d     = '0;
        end else if (s2_v_q) begin
            if (s2_nz_q && (err_q != '1)) begin
                err_d = err_q + CNT_W'(1);
            end
            abs_sum_d = (sum_ext > ACC_MAX) ? '1 : sum_ext[ACC_W-1:0];
            if (s2_abs_q > max_q) begin
                max_d = s2_abs_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            s1_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_r_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_nz_q   <= 1'b0;
            s2_abs_q  <= '0;
            err_q     <= '0;
            abs_sum_q <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            s1_v_q    <= s1_v_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_r_q    <= s1_r_d;
            s2_v_q    <= s2_v_d;
            s2_nz_q   <= s2_nz_d;
            s2_abs_q  <= s2_abs_d;
            err_q     <= err_d;
            abs_sum_q <= abs_sum_d;
            max_q     <= max_d;
        end
    end

`ifdef ERR_MON_SIGNED_ERR_EN
    // Sign-extend both terms so the sum can exceed the range before clamping
    always_comb begin
        sgn_ext = {{(SW-ACC_W-1){sgn_q[ACC_W]}}, sgn_q}
                + {{(SW-DW){s2_dif_q[DW-1]}}, s2_dif_q};
        sgn_d = sgn_q;
        if (clr) begin
            sgn_d = '0;
        end else if (s2_v_q) begin
            if (sgn_ext > SGN_MAX) begin
                sgn_d = SGN_MAX[ACC_W:0];
            end else if (sgn_ext < SGN_MIN) begin
                sgn_d = SGN_MIN[ACC_W:0];
            end else begin
                sgn_d = sgn_ext[ACC_W:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_dif_q <= '0;
            sgn_q    <= '0;
        end else begin
            s2_dif_q <= s2_dif_d;
            sgn_q    <= sgn_d;
        end
    end

    assign sum_sgn_err_o = sgn_q;
`else
    assign sum_sgn_err_o = '0;
`endif

    assign ready_o       = (state_q == RUN);
    assign busy_o        = (state_q == RUN) || (state_q == DRAIN);
    assign done_o        = done_q;
    assign err_count_o   = err_q;
    assign sum_abs_err_o = abs_sum_q;
    assign max_abs_err_o = max_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench for approx_adder_error_monitor: three instances cover
// the default window, a one-sample window and an 8-bit saturating accumulator.
module tb_approx_adder_error_monitor;

`ifdef ERR_MON_SIGNED_ERR_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_m = 1'b0;
    logic        start_o = 1'b0;
    logic        start_s = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [16:0] ap = '0;

    logic        rdy_m, busy_m, done_m;
    logic [15:0] err_m;
    logic [31:0] abs_m;
    logic [16:0] max_m;
    logic [32:0] sgn_m;

    logic        rdy_o, busy_o, done_o;
    logic [15:0] err_o;
    logic [31:0] abs_o;
    logic [16:0] max_o;
    logic [32:0] sgn_o;

    logic        rdy_s, busy_s, done_s;
    logic [15:0] err_s;
    logic [7:0]  abs_s;
    logic [16:0] max_s;
    logic [8:0]  sgn_s;

    int total = 0;
    int bad = 0;

    int     exp_err;
    longint exp_abs;
    longint exp_sgn;
    longint exp_max;

    always #5 clk = ~clk;

    approx_adder_error_monitor #(.NUM_SAMPLES(256)) u_main (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_m), .valid_i(valid),
        .ready_o(rdy_m), .add1_i(a), .add2_i(b), .approx_result_i(ap),
        .busy_o(busy_m), .done_o(done_m), .err_count_o(err_m),
        .sum_abs_err_o(abs_m), .max_abs_err_o(max_m), .sum_sgn_err_o(sgn_m)
    );

    approx_adder_error_monitor #(.NUM_SAMPLES(1)) u_one (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_o), .valid_i(valid),
        .ready_o(rdy_o), .add1_i(a), .add2_i(b), .approx_result_i(ap),
        .busy_o(busy_o), .done_o(done_o), .err_count_o(err_o),
        .sum_abs_err_o(abs_o), .max_abs_err_o(max_o), .sum_sgn_err_o(sgn_o)
    );

    approx_adder_error_monitor #(.NUM_SAMPLES(4), .ACC_W(8)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .valid_i(valid),
        .ready_o(rdy_s), .add1_i(a), .add2_i(b), .approx_result_i(ap),
        .busy_o(busy_s), .done_o(done_s), .err_count_o(err_s),
        .sum_abs_err_o(abs_s), .max_abs_err_o(max_s), .sum_sgn_err_o(sgn_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        exp_err = 0;
        exp_abs = 0;
        exp_sgn = 0;
        exp_max = 0;
    endfunction

    function automatic void model_add(input logic [15:0] x, input logic [15:0] y,
                                      input logic [16:0] r);
        longint d, m;
        d = longint'(r) - (longint'(x) + longint'(y));
        m = (d < 0) ? -d : d;
        if (d != 0) exp_err++;
        exp_abs += m;
        if (exp_abs > 64'hFFFF_FFFF) exp_abs = 64'hFFFF_FFFF;
        if (m > exp_max) exp_max = m;
        exp_sgn += d;
    endfunction

    task automatic start_main();
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
    endtask

    // mode 0: exact sums, mode 1: roughly two in three samples corrupted
    task automatic drive_window(input int mode, input bit gaps, input bit poke,
                                output int tx, output int last_c, output int done_c);
        int c;
        bit acc;
        logic [15:0] x, y;
        logic [16:0] r;
        tx = 0;
        last_c = -1;
        done_c = -1;
        c = 0;
        model_clear();
        while (!done_m && c < 4000) begin
            x = 16'($urandom);
            y = 16'($urandom);
            r = 17'(x) + 17'(y);
            if (mode == 1 && $urandom_range(0, 2) != 0) r = 17'($urandom);
            a = x;
            b = y;
            ap = r;
            valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start_m = poke && (c == 40);
            acc = valid && rdy_m;
            tick();
            c++;
            if (acc) begin
                model_add(x, y, r);
                tx++;
                last_c = c;
            end
        end
        if (done_m) done_c = c;
        valid = 1'b0;
        start_m = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (rdy_m !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", rdy_m); end
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy_m); end
        total++; if (done_m !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done_m); end
        total++; if (err_m !== 16'd0) begin bad++; $display("FAIL rst_err got=%0h want=0", err_m); end
        total++; if (abs_m !== 32'd0) begin bad++; $display("FAIL rst_abs got=%0h want=0", abs_m); end
        total++; if (max_m !== 17'd0) begin bad++; $display("FAIL rst_max got=%0h want=0", max_m); end
        total++; if (sgn_m !== 33'd0) begin bad++; $display("FAIL rst_sgn got=%0h want=0", sgn_m); end
        #10;
        rst_n = 1'b1;
        tick();
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got=%0b want=0", busy_m); end
    endtask

    task automatic test_single();
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        total++; if (rdy_o !== 1'b1) begin bad++; $display("FAIL one_ready got=%0b want=1", rdy_o); end
        a = 16'h0003;
        b = 16'h0001;
        ap = 17'h00005;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        total++; if (rdy_o !== 1'b0) begin bad++; $display("FAIL one_drain_ready got=%0b want=0", rdy_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL one_drain_busy got=%0b want=1", busy_o); end
        tick();
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL one_early_done got=%0b want=0", done_o); end
        tick();
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL one_done got=%0b want=1", done_o); end
        total++; if (err_o !== 16'd1) begin bad++; $display("FAIL one_err got=%0h want=1", err_o); end
        total++; if (abs_o !== 32'd1) begin bad++; $display("FAIL one_abs got=%0h want=1", abs_o); end
        total++; if (max_o !== 17'd1) begin bad++; $display("FAIL one_max got=%0h want=1", max_o); end
        total++; if (sgn_o !== (SGN_EN ? 33'd1 : 33'd0)) begin bad++; $display("FAIL one_sgn got=%0h want=%0h", sgn_o, SGN_EN ? 1 : 0); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL one_done_busy got=%0b want=0", busy_o); end
    endtask

    task automatic test_saturation();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        ap = 17'h1FFFF;
        valid = 1'b1;
        repeat (4) tick();
        valid = 1'b0;
        tick();
        tick();
        total++; if (done_s !== 1'b1) begin bad++; $display("FAIL sat_done got=%0b want=1", done_s); end
        total++; if (err_s !== 16'd4) begin bad++; $display("FAIL sat_err got=%0h want=4", err_s); end
        total++; if (abs_s !== 8'hFF) begin bad++; $display("FAIL sat_abs got=%0h want=ff", abs_s); end
        total++; if (max_s !== 17'h1FFFF) begin bad++; $display("FAIL sat_max got=%0h want=1ffff", max_s); end
        total++; if (sgn_s !== (SGN_EN ? 9'h0FF : 9'h000)) begin bad++; $display("FAIL sat_sgn_pos got=%0h want=%0h", sgn_s, SGN_EN ? 9'h0FF : 9'h0); end
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        total++; if (done_s !== 1'b0) begin bad++; $display("FAIL sat_restart_done got=%0b want=0", done_s); end
        total++; if (abs_s !== 8'h00) begin bad++; $display("FAIL sat_restart_abs got=%0h want=0", abs_s); end
        total++; if (max_s !== 17'h0) begin bad++; $display("FAIL sat_restart_max got=%0h want=0", max_s); end
        a = 16'hFFFF;
        b = 16'hFFFF;
        ap = 17'h00000;
        valid = 1'b1;
        repeat (4) tick();
        valid = 1'b0;
        tick();
        tick();
        total++; if (done_s !== 1'b1) begin bad++; $display("FAIL sat_neg_done got=%0b want=1", done_s); end
        total++; if (abs_s !== 8'hFF) begin bad++; $display("FAIL sat_neg_abs got=%0h want=ff", abs_s); end
        total++; if (max_s !== 17'h1FFFE) begin bad++; $display("FAIL sat_neg_max got=%0h want=1fffe", max_s); end
        total++; if (sgn_s !== (SGN_EN ? 9'h100 : 9'h000)) begin bad++; $display("FAIL sat_sgn_neg got=%0h want=%0h", sgn_s, SGN_EN ? 9'h100 : 9'h0); end
    endtask

    task automatic test_exact();
        int tx, lc, dc;
        start_main();
        total++; if (busy_m !== 1'b1) begin bad++; $display("FAIL exact_busy got=%0b want=1", busy_m); end
        drive_window(0, 1'b0, 1'b0, tx, lc, dc);
        total++; if (tx !== 256) begin bad++; $display("FAIL exact_tx got=%0d want=256", tx); end
        total++; if (dc - lc !== 2) begin bad++; $display("FAIL exact_latency got=%0d want=2", dc - lc); end
        total++; if (err_m !== 16'd0) begin bad++; $display("FAIL exact_err got=%0h want=0", err_m); end
        total++; if (abs_m !== 32'd0) begin bad++; $display("FAIL exact_abs got=%0h want=0", abs_m); end
        total++; if (max_m !== 17'd0) begin bad++; $display("FAIL exact_max got=%0h want=0", max_m); end
    endtask

    task automatic test_backpressure();
        int tx, lc, dc;
        start_main();
        drive_window(1, 1'b1, 1'b1, tx, lc, dc);
        total++; if (done_m !== 1'b1) begin bad++; $display("FAIL bp_done got=%0b want=1", done_m); end
        total++; if (tx !== 256) begin bad++; $display("FAIL bp_tx got=%0d want=256", tx); end
        total++; if (dc - lc !== 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", dc - lc); end
        total++; if (err_m !== 16'(exp_err)) begin bad++; $display("FAIL bp_err got=%0h want=%0h", err_m, exp_err); end
        total++; if (abs_m !== 32'(exp_abs)) begin bad++; $display("FAIL bp_abs got=%0h want=%0h", abs_m, exp_abs); end
        total++; if (max_m !== 17'(exp_max)) begin bad++; $display("FAIL bp_max got=%0h want=%0h", max_m, exp_max); end
        total++; if (sgn_m !== (SGN_EN ? 33'(exp_sgn) : 33'd0)) begin bad++; $display("FAIL bp_sgn got=%0h want=%0h", sgn_m, SGN_EN ? 33'(exp_sgn) : 33'd0); end
    endtask

    task automatic test_reset_mid();
        int tx, lc, dc;
        start_main();
        a = 16'h1234;
        b = 16'h0001;
        ap = 17'h00000;
        valid = 1'b1;
        repeat (10) tick();
        valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #2;
        total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy_m); end
        total++; if (done_m !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b want=0", done_m); end
        total++; if (err_m !== 16'd0) begin bad++; $display("FAIL mid_err got=%0h want=0", err_m); end
        total++; if (abs_m !== 32'd0) begin bad++; $display("FAIL mid_abs got=%0h want=0", abs_m); end
        total++; if (max_m !== 17'd0) begin bad++; $display("FAIL mid_max got=%0h want=0", max_m); end
        rst_n = 1'b1;
        tick();
        total++; if (rdy_m !== 1'b0) begin bad++; $display("FAIL mid_idle_ready got=%0b want=0", rdy_m); end
        start_main();
        drive_window(1, 1'b0, 1'b0, tx, lc, dc);
        total++; if (tx !== 256) begin bad++; $display("FAIL mid_tx got=%0d want=256", tx); end
        total++; if (err_m !== 16'(exp_err)) begin bad++; $display("FAIL mid_win_err got=%0h want=%0h", err_m, exp_err); end
        total++; if (abs_m !== 32'(exp_abs)) begin bad++; $display("FAIL mid_win_abs got=%0h want=%0h", abs_m, exp_abs); end
        total++; if (max_m !== 17'(exp_max)) begin bad++; $display("FAIL mid_win_max got=%0h want=%0h", max_m, exp_max); end
    endtask

    task automatic test_back_to_back();
        int tx, lc, dc;
        total++; if (done_m !== 1'b1) begin bad++; $display("FAIL b2b_pre_done got=%0b want=1", done_m); end
        start_main();
        total++; if (done_m !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%0b want=0", done_m); end
        total++; if (err_m !== 16'd0) begin bad++; $display("FAIL b2b_clr_err got=%0h want=0", err_m); end
        total++; if (abs_m !== 32'd0) begin bad++; $display("FAIL b2b_clr_abs got=%0h want=0", abs_m); end
        total++; if (max_m !== 17'd0) begin bad++; $display("FAIL b2b_clr_max got=%0h want=0", max_m); end
        total++; if (sgn_m !== 33'd0) begin bad++; $display("FAIL b2b_clr_sgn got=%0h want=0", sgn_m); end
        drive_window(1, 1'b1, 1'b0, tx, lc, dc);
        total++; if (tx !== 256) begin bad++; $display("FAIL b2b_tx got=%0d want=256", tx); end
        total++; if (err_m !== 16'(exp_err)) begin bad++; $display("FAIL b2b_err got=%0h want=%0h", err_m, exp_err); end
        total++; if (abs_m !== 32'(exp_abs)) begin bad++; $display("FAIL b2b_abs got=%0h want=%0h", abs_m, exp_abs); end
        total++; if (max_m !== 17'(exp_max)) begin bad++; $display("FAIL b2b_max got=%0h want=%0h", max_m, exp_max); end
        total++; if (sgn_m !== (SGN_EN ? 33'(exp_sgn) : 33'd0)) begin bad++; $display("FAIL b2b_sgn got=%0h want=%0h", sgn_m, SGN_EN ? 33'(exp_sgn) : 33'd0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_exact();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
